// File: rtl/pipe_game_pkg.sv
// Shared types and geometry defaults for the pipe game: state encoding,
// sprite sizes, lane count and coordinate width.
package pipe_game_pkg;

  localparam int COORD_W   = 10;
  localparam int SUM_W     = COORD_W + 1;
  localparam int NUM_LANES = 3;

  localparam int BIRD_X_DEF      = 100;
  localparam int BIRD_W_DEF      = 34;
  localparam int BIRD_H_DEF      = 24;
  localparam int PIPE_W_DEF      = 52;
  localparam int FLOOR_Y_DEF     = 440;
  localparam int SCORE_MAX_DEF   = 999;
  localparam int DEAD_FRAMES_DEF = 60;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SUM_W-1:0]   wide_t;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_DEAD = 2'd2
  } game_state_t;

  // Coordinate plus a sprite offset, one bit wider so the sum never wraps.
  function automatic wide_t widen(coord_t v, int unsigned off);
    return wide_t'(v) + wide_t'(off);
  endfunction

endpackage

// File: rtl/pipe_collision_scorer_if.sv
// Bus between the pipe animator / bird logic and the collision scorer.
interface pipe_collision_scorer_if;
  import pipe_game_pkg::*;

  logic                           start;
  coord_t                         birdY;
  logic [NUM_LANES*COORD_W-1:0]   pipeX;
  logic [NUM_LANES*COORD_W-1:0]   gapTop;
  logic [NUM_LANES*COORD_W-1:0]   gapBottom;
  logic [NUM_LANES-1:0]           pipeEn;
  coord_t                         score;
  logic [1:0]                     gameState;
  logic                           hit;
  logic                           scoreTick;
  coord_t                         bestScore;

  modport master (
    output start, birdY, pipeX, gapTop, gapBottom, pipeEn,
    input  score, gameState, hit, scoreTick, bestScore
  );

  modport slave (
    input  start, birdY, pipeX, gapTop, gapBottom, pipeEn,
    output score, gameState, hit, scoreTick, bestScore
  );

endinterface

// File: rtl/pipe_lane_checker.sv
// One pipe lane: combinational bird overlap / pass detection plus the
// registered "already scored" flag for that lane.
module pipe_lane_checker
  import pipe_game_pkg::*;
#(
  parameter int BIRD_X = BIRD_X_DEF,
  parameter int BIRD_W = BIRD_W_DEF,
  parameter int BIRD_H = BIRD_H_DEF,
  parameter int PIPE_W = PIPE_W_DEF
) (
  input  logic   animationCLOCK,
  input  logic   resetN,
  input  coord_t birdY,
  input  coord_t pipeX,
  input  coord_t gapTop,
  input  coord_t gapBottom,
  input  logic   pipeEn,
  input  logic   clear,
  input  logic   take,
  output logic   collide,
  output logic   passCand
);

  logic  passed;
  wide_t pipe_right;
  wide_t bird_bottom;
  logic  overlap_x;
  logic  outside_gap;
  logic  respawned;

  assign pipe_right  = widen(pipeX, PIPE_W);
  assign bird_bottom = widen(birdY, BIRD_H);
  assign overlap_x   = (wide_t'(pipeX) < wide_t'(BIRD_X + BIRD_W)) &&
                       (pipe_right > wide_t'(BIRD_X));
  // An inverted gap (top below bottom) makes this true for every birdY.
  assign outside_gap = (birdY < gapTop) || (bird_bottom > wide_t'(gapBottom));
  assign respawned   = wide_t'(pipeX) >= wide_t'(BIRD_X);

  assign collide  = pipeEn && overlap_x && outside_gap;
  assign passCand = pipeEn && (pipe_right <= wide_t'(BIRD_X)) && !passed;

  // NOTE: state registers use non-blocking assignments and the async reset
  // branch comes first, so every flop clears the instant resetN falls.
  always_ff @(posedge animationCLOCK or negedge resetN) begin
    if (!resetN)                passed <= 1'b0;
    else if (clear)             passed <= 1'b0;
    else if (take && passCand)  passed <= 1'b1;
    else if (!pipeEn || respawned) passed <= 1'b0;
  end

endmodule

// File: rtl/pipe_collision_scorer.sv
// Game FSM (idle/play/dead), collision detection and saturating score.
// Optional best-score register is built when PIPE_BEST_SCORE_EN is defined.
module pipe_collision_scorer
  import pipe_game_pkg::*;
#(
  parameter int BIRD_X      = BIRD_X_DEF,
  parameter int BIRD_W      = BIRD_W_DEF,
  parameter int BIRD_H      = BIRD_H_DEF,
  parameter int PIPE_W      = PIPE_W_DEF,
  parameter int FLOOR_Y     = FLOOR_Y_DEF,
  parameter int SCORE_MAX   = SCORE_MAX_DEF,
  parameter int DEAD_FRAMES = DEAD_FRAMES_DEF
) (
  input logic                    animationCLOCK,
  input logic                    resetN,
  pipe_collision_scorer_if.slave bus
);

  localparam int CNT_W = $clog2(DEAD_FRAMES + 1);

  game_state_t          state;
  coord_t               score;
  logic                 hit;
  logic                 scoreTick;
  logic                 start_d;
  logic [CNT_W-1:0]     dead_cnt;

  logic [NUM_LANES-1:0] lane_collide;
  logic [NUM_LANES-1:0] pass_cand;
  logic [1:0]           pass_cnt;
  logic                 start_rise;
  logic                 crash;
  logic                 take;
  logic                 clear;
  wide_t                score_sum;
  coord_t               score_next;

  assign start_rise = bus.start && !start_d;
  assign crash      = (|lane_collide) ||
                      (widen(bus.birdY, BIRD_H) >= wide_t'(FLOOR_Y));
  assign take       = (state == GS_PLAY) && !crash;
  assign clear      = (state == GS_IDLE) && start_rise;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pipe_lane_checker #(
      .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H), .PIPE_W(PIPE_W)
    ) u_lane (
      .animationCLOCK (animationCLOCK),
      .resetN         (resetN),
      .birdY          (bus.birdY),
      .pipeX          (bus.pipeX[i*COORD_W +: COORD_W]),
      .gapTop         (bus.gapTop[i*COORD_W +: COORD_W]),
      .gapBottom      (bus.gapBottom[i*COORD_W +: COORD_W]),
      .pipeEn         (bus.pipeEn[i]),
      .clear          (clear),
      .take           (take),
      .collide        (lane_collide[i]),
      .passCand       (pass_cand[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) pass_cnt = pass_cnt + 2'(pass_cand[i]);
  end

  assign score_sum  = wide_t'(score) + wide_t'(pass_cnt);
  assign score_next = (score_sum > wide_t'(SCORE_MAX)) ? COORD_W'(SCORE_MAX)
                                                       : score_sum[COORD_W-1:0];

  always_ff @(posedge animationCLOCK or negedge resetN) begin
    if (!resetN) begin
      state     <= GS_IDLE;
      score     <= '0;
      hit       <= 1'b0;
      scoreTick <= 1'b0;
      start_d   <= 1'b0;
      dead_cnt  <= '0;
    end else begin
      start_d   <= bus.start;
      hit       <= 1'b0;
      scoreTick <= 1'b0;
      unique case (state)
        GS_IDLE: if (start_rise) begin
          state <= GS_PLAY;
          score <= '0;
        end
        GS_PLAY: if (crash) begin
          state    <= GS_DEAD;
          hit      <= 1'b1;
          dead_cnt <= CNT_W'(DEAD_FRAMES - 1);
        end else begin
          score     <= score_next;
          scoreTick <= |pass_cand;
        end
        // Counter parks at zero while the button is held.
        GS_DEAD: if (dead_cnt != '0)  dead_cnt <= dead_cnt - CNT_W'(1);
                 else if (!bus.start) state    <= GS_IDLE;
        default: state <= GS_IDLE;
      endcase
    end
  end

`ifdef PIPE_BEST_SCORE_EN
  coord_t best_q;

  always_ff @(posedge animationCLOCK or negedge resetN) begin
    if (!resetN)                                   best_q <= '0;
    else if (state == GS_PLAY && crash && score > best_q) best_q <= score;
  end

  assign bus.bestScore = best_q;
`else
  assign bus.bestScore = '0;
`endif

  assign bus.score     = score;
  assign bus.gameState = state;
  assign bus.hit       = hit;
  assign bus.scoreTick = scoreTick;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed + randomized bench for pipe_collision_scorer against a
// behavioural game model derived from the game rules.
module tb_pipe_collision_scorer;

  localparam int BX = 100, BW = 34, BH = 24, PW = 52, FY = 440;
  localparam int SMAX = 999, DEADF = 60;

  logic animationCLOCK = 1'b0;
  logic resetN;

  pipe_collision_scorer_if bus ();

  pipe_collision_scorer dut (
    .animationCLOCK (animationCLOCK),
    .resetN         (resetN),
    .bus            (bus)
  );

  always #5 animationCLOCK = ~animationCLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_state, m_score, m_best, m_hit, m_tick, m_dead, m_start_d;
  int m_passed [3];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_best = 0; m_hit = 0; m_tick = 0;
    m_dead = 0; m_start_d = 0;
    for (int i = 0; i < 3; i++) m_passed[i] = 0;
  endtask

  task automatic model_step();
    int by, x, gt, gb, en, n, old_state;
    bit rise, crash;
    bit cand [3];
    by    = int'(bus.birdY);
    rise  = bus.start && (m_start_d == 0);
    crash = (by + BH >= FY);
    for (int i = 0; i < 3; i++) begin
      x  = int'(bus.pipeX[i*10 +: 10]);
      gt = int'(bus.gapTop[i*10 +: 10]);
      gb = int'(bus.gapBottom[i*10 +: 10]);
      en = int'(bus.pipeEn[i]);
      if (en != 0 && x < BX + BW && x + PW > BX && (by < gt || by + BH > gb)) crash = 1;
      cand[i] = (en != 0) && (x + PW <= BX) && (m_passed[i] == 0);
    end
    old_state = m_state;
    m_hit = 0; m_tick = 0;
    // Passed flags drop whenever a lane is disabled or back at/after the bird
    for (int i = 0; i < 3; i++)
      if (!bus.pipeEn[i] || int'(bus.pipeX[i*10 +: 10]) >= BX) m_passed[i] = 0;
    case (old_state)
      0: if (rise) begin
        m_state = 1; m_score = 0;
        for (int i = 0; i < 3; i++) m_passed[i] = 0;
      end
      1: if (crash) begin
        m_state = 2; m_hit = 1; m_dead = DEADF - 1;
`ifdef PIPE_BEST_SCORE_EN
        if (m_score > m_best) m_best = m_score;
`endif
      end else begin
        n = 0;
        for (int i = 0; i < 3; i++) if (cand[i]) begin n++; m_passed[i] = 1; end
        m_score = (m_score + n > SMAX) ? SMAX : m_score + n;
        m_tick  = (n > 0);
      end
      default: if (m_dead == 0) begin
        if (!bus.start) m_state = 0;
      end else m_dead--;
    endcase
    m_start_d = bus.start;
  endtask

  task automatic step();
    @(posedge animationCLOCK);
    #1;
    model_step();
    check("state", int'(bus.gameState), m_state);
    check("score", int'(bus.score), m_score);
    check("hit",   int'(bus.hit), m_hit);
    check("tick",  int'(bus.scoreTick), m_tick);
    check("best",  int'(bus.bestScore), m_best);
  endtask

  task automatic set_lane(input int i, input int x, input int gt, input int gb, input bit en);
    bus.pipeX[i*10 +: 10]     = 10'(x);
    bus.gapTop[i*10 +: 10]    = 10'(gt);
    bus.gapBottom[i*10 +: 10] = 10'(gb);
    bus.pipeEn[i]             = en;
  endtask

  task automatic lanes_off();
    for (int i = 0; i < 3; i++) set_lane(i, 200, 150, 300, 1'b0);
  endtask

  task automatic start_game();
    bus.start = 1'b0; step();
    bus.start = 1'b1; step();
    bus.start = 1'b0;
  endtask

  // Steps until IDLE; returns the number of sampled cycles still in DEAD.
  task automatic wait_idle(input int bound, output int dwell);
    dwell = 1;
    for (int k = 0; k < bound; k++) begin
      step();
      if (bus.gameState != 2'd2) return;
      dwell++;
    end
    check("idle_timeout", int'(bus.gameState), 0);
  endtask

  int hits, ticks, hit_x, dwell;
  int best_exp;

  initial begin
    resetN = 1'b0;
    bus.start = 1'b0; bus.birdY = 10'd200;
    lanes_off();
    model_reset();
    #12;
    check("rst_state", int'(bus.gameState), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_hit",   int'(bus.hit), 0);
    check("rst_tick",  int'(bus.scoreTick), 0);
    check("rst_best",  int'(bus.bestScore), 0);
    @(negedge animationCLOCK); resetN = 1'b1;

    // Start edge enters PLAY next cycle
    step();
    bus.start = 1'b1; step();
    check("start_play", int'(bus.gameState), 1);
    check("start_score", int'(bus.score), 0);
    bus.start = 1'b0;

    // Lane 0 sweeps past a bird inside the gap: exactly one point
    hits = 0; ticks = 0;
    for (int x = 120; x >= 40; x -= 4) begin
      set_lane(0, x, 150, 300, 1'b1);
      step();
      hits  += int'(bus.hit);
      ticks += int'(bus.scoreTick);
    end
    check("sweep_score", int'(bus.score), 1);
    check("sweep_ticks", ticks, 1);
    check("sweep_hits",  hits, 0);

    // Bird above the gap: hit when the pipe first overlaps (x < 134)
    set_lane(0, 200, 150, 300, 1'b1); step();
    bus.birdY = 10'd100;
    hit_x = -1;
    for (int x = 140; x >= 100; x -= 2) begin
      set_lane(0, x, 150, 300, 1'b1);
      step();
      if (bus.hit) begin hit_x = x; break; end
    end
    check("hit_x", hit_x, 132);
    check("hit_state", int'(bus.gameState), 2);
    check("hit_score", int'(bus.score), 1);

    // Holding start keeps the game in DEAD; releasing returns to IDLE
    bus.start = 1'b1;
    for (int k = 0; k < 100; k++) step();
    check("dead_hold", int'(bus.gameState), 2);
    bus.start = 1'b0; step();
    check("dead_release", int'(bus.gameState), 0);

    // Two lanes pass in the same frame: +2 with one tick
    bus.birdY = 10'd200;
    start_game();
    set_lane(0, 200, 150, 300, 1'b1); set_lane(1, 200, 150, 300, 1'b1); step();
    set_lane(0, 40, 150, 300, 1'b1);  set_lane(1, 48, 150, 300, 1'b1);  step();
    check("dual_score", int'(bus.score), 2);
    check("dual_tick", int'(bus.scoreTick), 1);
    step();
    check("dual_tick_pulse", int'(bus.scoreTick), 0);

    // Floor collision and exact DEAD dwell
    bus.birdY = 10'd420; step();
    check("floor_hit", int'(bus.hit), 1);
    bus.birdY = 10'd200;
    wait_idle(200, dwell);
    check("dead_dwell", dwell, DEADF);

    // Drive score to saturation: triples to 996, then doubles past 999
    start_game();
    for (int k = 0; k < 334; k++) begin
      for (int i = 0; i < 3; i++) set_lane(i, 200, 150, 300, (k < 332) || (i < 2));
      step();
      for (int i = 0; i < 3; i++) set_lane(i, 0, 150, 300, (k < 332) || (i < 2));
      step();
    end
    check("sat_score", int'(bus.score), SMAX);
    bus.birdY = 10'd430; step();
`ifdef PIPE_BEST_SCORE_EN
    best_exp = SMAX;
`else
    best_exp = 0;
`endif
    check("sat_best", int'(bus.bestScore), best_exp);
    bus.birdY = 10'd200;
    wait_idle(200, dwell);

    // Asynchronous reset in the middle of a game
    lanes_off();
    start_game();
    set_lane(2, 200, 150, 300, 1'b1); step();
    set_lane(2, 10, 150, 300, 1'b1);  step();
    check("pre_rst_score", int'(bus.score), 1);
    @(posedge animationCLOCK); #3;
    resetN = 1'b0; #1;
    model_reset();
    check("async_state", int'(bus.gameState), 0);
    check("async_score", int'(bus.score), 0);
    check("async_best",  int'(bus.bestScore), 0);
    @(negedge animationCLOCK); resetN = 1'b1;

    // Randomized play checked cycle by cycle against the model
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
      bus.birdY = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(150, 276))
                                             : 10'($urandom_range(0, 470));
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 4) == 0)
          set_lane(i, $urandom_range(0, 300), $urandom_range(0, 400),
                   $urandom_range(0, 450), 1'($urandom_range(0, 3) != 0));
        else
          set_lane(i, $urandom_range(0, 300), 150, 300,
                   1'($urandom_range(0, 4) != 0));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_collision_scorer.md
# pipe_collision_scorer

Consumes the three pipe lanes driven by the pipe animator plus the bird position. Runs the game state machine: idle, playing, dead. Detects bird/pipe and bird/floor collisions, counts pipes passed, and drives the `score` value that the animator uses for pipe speed and gap sizing. Evaluates once per animation frame tick on the animation clock.

## Interface
Parameters:
- BIRD_X, 100: fixed left column of the bird sprite (pixels)
- BIRD_W, 34: bird width
- BIRD_H, 24: bird height
- PIPE_W, 52: pipe sprite width
- FLOOR_Y, 440: first row of floor; bird bottom reaching it is a collision
- SCORE_MAX, 999: score saturation value
- DEAD_FRAMES, 60: frames held in DEAD before returning to IDLE

Ports:
- animationCLOCK  in  1  frame-rate clock; all state on rising edge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  player button (mouse1 level); rising edge used
- birdY  in  10  bird top row
- pipeX  in  30  three 10-bit lane X positions, lane0 in [9:0]
- gapTop  in  30  per-lane first open row
- gapBottom  in  30  per-lane first blocked row below gap
- pipeEn  in  3  per-lane active flag
- score  out  10  current score
- gameState  out  2  0 IDLE, 1 PLAY, 2 DEAD
- hit  out  1  one-cycle pulse on the PLAY→DEAD transition
- scoreTick  out  1  one-cycle pulse whenever score increments
- bestScore  out  10  best score (see Configuration)

## Operation
- FSM states: IDLE, PLAY, DEAD.
  - IDLE→PLAY on a start rising edge (start=1, previous start=0). Clears score and all lane passed flags.
  - PLAY→DEAD when any lane collides, or when birdY+BIRD_H ≥ FLOOR_Y.
  - DEAD decrements a frame counter loaded with DEAD_FRAMES-1. At 0 with start=0 it goes to IDLE. While start=1 it stays at 0 and holds.
- Lane collision requires all of the following:
  - pipeEn[i]=1
  - pipeX[i] < BIRD_X+BIRD_W
  - pipeX[i]+PIPE_W > BIRD_X
  - birdY < gapTop[i] or birdY+BIRD_H > gapBottom[i]
- Arithmetic: all sums are computed 11 bits wide, so there is no wrap. gapTop > gapBottom is treated as a fully closed lane.
- Scoring applies in PLAY only. Each lane has a passed flag. A lane scores when pipeEn[i]=1, pipeX[i]+PIPE_W ≤ BIRD_X, and passed=0; that sets passed=1. The passed flag clears when pipeEn[i]=0 or when pipeX[i] ≥ BIRD_X (lane respawned).
- Simultaneous passes: score adds the number of scoring lanes (0–3) in one cycle and saturates at SCORE_MAX. scoreTick asserts if the sum is nonzero.
- Collision and pass in the same cycle: collision wins. No score is added and the FSM enters DEAD.
- In IDLE and DEAD, score holds and no scoring occurs. Collisions are ignored outside PLAY.

## Timing
- Reset values:
  - state IDLE
  - score 0, bestScore 0
  - hit 0, scoreTick 0
  - passed flags 0, start history 0
  - DEAD counter 0
- All outputs are registered. Inputs sampled at edge N are reflected on outputs after edge N (1-cycle latency).
- hit and scoreTick are single-cycle pulses.
- Reset asserted mid-game forces IDLE immediately (asynchronously) with score 0.
- DEAD dwell with start=0 is exactly DEAD_FRAMES cycles.

## Configuration
- PIPE_BEST_SCORE_EN:
  - Defined: bestScore register updates to score on the PLAY→DEAD edge if score > bestScore. It survives games and is cleared only by resetN.
  - Undefined: bestScore is tied to 0 and no register is built.

## Structure
- Shared package `pipe_game_pkg`:
  - gameState encodings (IDLE/PLAY/DEAD)
  - sprite dimension defaults (bird, pipe width, floor row)
  - lane count 3
  - coordinate width 10
- Sub-module `pipe_lane_checker`, instantiated once per lane:
  - combinational collide and pass-candidate outputs
  - registered passed flag
- The top level holds the FSM, the adder/saturation logic, the start edge detector and the DEAD counter.

## Test plan
- Reset, then start 0→1 → gameState=1 the next cycle, score=0.
- PLAY, lane0 pipeEn=1, pipeX stepping 120→40, birdY=200, gap 150..300 → score 0→1 once, scoreTick one pulse, no hit.
- Same sweep with birdY=100 (above gap) → hit pulse at the first cycle pipeX<134, gameState=2, score unchanged.
- Lanes 0 and 1 both reach pipeX+52 ≤ 100 in the same cycle → score +2, single scoreTick.
- birdY=420 (420+24 ≥ 440) → DEAD. Hold start=0 → IDLE after exactly 60 cycles. Hold start=1 → stays DEAD.
- Score forced near 998 with two simultaneous passes → 999 saturated. With PIPE_BEST_SCORE_EN, bestScore=999 after death; mid-game resetN low → score=0, state IDLE.
